// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use bubbles, EX redirects,
// fixed-latency data-memory freeze, plus stall/flush performance counters.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  RUN   | pipeline flowing; a MEM access starts a freeze (if MEM_LAT != 0)
//  WAIT  | memory access in flight; frozen while cnt != 0, released at cnt == 0
module hazard_ctrl #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_branch_taken_i,
    input  logic [31:0]      ex_target_i,
    input  logic             mem_access_i,
    output logic             stall_o,
    output logic             branch_o,
    output logic [31:0]      addr_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_mem_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o
);

    localparam int unsigned CNT_BITS = (MEM_LAT == 0) ? 1 : $clog2(MEM_LAT + 1);
    localparam bit          HAS_LAT  = (MEM_LAT != 0);
    localparam logic [CNT_BITS-1:0] CNT_INIT =
        (MEM_LAT == 0) ? '0 : CNT_BITS'(MEM_LAT - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]    flush_events_q, flush_events_d;

    logic freeze;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired, so a load targeting it never produces a dependency.
    assign rs1_hit  = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit  = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        freeze      = 1'b0;
        stall_o     = 1'b0;
        branch_o    = 1'b0;
        addr_o      = 32'd0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        stall_mem_o = 1'b0;
        flush_id_o  = 1'b0;
        flush_ex_o  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_access_i && HAS_LAT) begin
                    freeze  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_WAIT: begin
                // The cnt == 0 cycle is the release cycle: the pipeline advances
                // and any MEM access seen here belongs to the finishing instruction.
                if (cnt_q != '0) begin
                    freeze = 1'b1;
                    cnt_d  = cnt_q - CNT_BITS'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        if (!rst_i) begin
            if (freeze) begin
                stall_o     = 1'b1;
                stall_id_o  = 1'b1;
                stall_ex_o  = 1'b1;
                stall_mem_o = 1'b1;
            end else if (ex_branch_taken_i) begin
                branch_o   = 1'b1;
                addr_o     = ex_target_i;
                flush_id_o = 1'b1;
                flush_ex_o = 1'b1;
            end else if (load_use) begin
                stall_o    = 1'b1;
                stall_id_o = 1'b1;
                flush_ex_o = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, stall_o};
        flush_events_d = flush_events_q + {{(CNT_W-1){1'b0}}, branch_o};
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_events_o = flush_events_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RISC-V core.
- Drives the IF stage's stall, Branch and Addr inputs, plus the stall and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards, redirects fetch on taken branches/jumps resolved in EX, and freezes the pipeline while a fixed-latency data-memory access completes.
- Keeps stall-cycle and flush-event performance counters.

Parameters:
- MEM_LAT, 2, data-memory access latency in freeze cycles per load/store (0 = single-cycle memory, never freezes).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- ex_target  in  32  redirect target from EX.
- mem_access  in  1  MEM stage holds a load/store this cycle.
- stall  out  1  to IF: hold PC.
- Branch  out  1  to IF: load PC from Addr.
- Addr  out  32  to IF: redirect target.
- stall_id  out  1  hold the IF/ID register.
- stall_ex  out  1  hold the ID/EX register.
- stall_mem  out  1  hold the EX/MEM register.
- flush_id  out  1  clear IF/ID to a NOP.
- flush_ex  out  1  clear ID/EX to a NOP.
- stall_cycles  out  CNT_W  count of cycles with stall=1.
- flush_events  out  CNT_W  count of redirects.

Behaviour:
- FSM states: RUN, WAIT. Register cnt is clog2(MEM_LAT+1) bits wide.
- Reset (rst=1 at an edge): state<=RUN, cnt<=0, stall_cycles<=0, flush_events<=0.
- While rst=1, all combinational control outputs are forced to 0 and Addr=0. The same applies if rst asserts mid-WAIT; the freeze is abandoned.
- freeze = (state==RUN && mem_access && MEM_LAT!=0) || (state==WAIT && cnt!=0).
- Transitions:
  - RUN -> WAIT when mem_access && MEM_LAT!=0; cnt<=MEM_LAT-1.
  - WAIT with cnt!=0: cnt<=cnt-1.
  - WAIT with cnt==0: return to RUN; the pipeline advances that cycle.
  - A mem_access in the following cycle belongs to the next instruction and retriggers normally.
- Freeze length per access: exactly MEM_LAT cycles.
- Freeze (highest priority):
  - stall=stall_id=stall_ex=stall_mem=1; Branch=0; flush_id=flush_ex=0.
  - EX keeps its instruction, so a pending ex_branch_taken is honoured on the first unfrozen cycle.
- Redirect (not freeze, ex_branch_taken=1):
  - Branch=1, Addr=ex_target, flush_id=1, flush_ex=1, stall=0.
  - Overrides load-use: the dependent instruction is squashed anyway.
- Load-use (not freeze, no redirect):
  - Condition: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - Response: stall=1, stall_id=1, flush_ex=1 (bubble). stall_ex=stall_mem=0.
  - Lasts exactly one cycle, because the load leaves EX.
- Otherwise all controls are 0.
- Addr is ex_target whenever Branch=1; otherwise 0.
- Counters: stall_cycles +1 on each edge where stall=1 (freeze or load-use). flush_events +1 on each edge where Branch=1. Both wrap modulo 2^CNT_W and are held during rst.
- x0 never creates a hazard.

Test Plan:
- Reset then idle: all controls 0, counters 0; IF PC advances +4 per cycle from 0x3000.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of stall=stall_id=flush_ex=1, then all 0; stall_cycles=1.
- Same as above with ex_rd=0 -> no stall. With ex_rd=5 but id_use_rs2=0 -> no stall.
- Branch plus simultaneous load-use: ex_branch_taken=1, ex_target=0x3040 -> Branch=1, Addr=0x3040, flush_id=flush_ex=1, stall=0; next PC=0x3040; flush_events=1.
- MEM_LAT=2, mem_access held high, with ex_branch_taken=1 during the freeze:
  - Required: freeze exactly 2 cycles with Branch=0.
  - Then Branch=1 in the 3rd cycle.
  - stall_cycles=2, flush_events=1.
- Reset mid-freeze: rst in WAIT -> next cycle RUN, outputs 0, counters 0. Counter wrap with CNT_W=4: 16 stall cycles -> stall_cycles=0.
